fu_issue_select: RTL and testbench
==================================

// Module: fu_issue_select
// PURPOSE
//  N-way issue selector + registered issue stage between RS issue slots and one functional unit.
//  Each cycle picks one ready RS slot, grants it back to the RS, and latches its operands, tag,
//  control, branch mask and stack pointer into the FU input register.
//  Honours FU backpressure and squashes held/requesting entries on branch mispredict.
// PARAMETERS
//  N_REQ     2    number of RS request slots (>=2)
//  DATA_W    64   operand width
//  TAG_W     6    physical destination tag width
//  CTRL_W    179  decoded control bundle width
//  BMASK_W   4    branch mask width (one bit per in-flight branch)
//  BSPTR_W   2    branch stack pointer width
//  ZERO_TAG  {TAG_W{1'b1}}  tag driven when output invalid (physical zero reg)
// PORTS
//  clock          in   1               rising-edge clock
//  reset          in   1               synchronous, active-high
//  rs_fu_en       in   N_REQ           per-slot request valid
//  rf_opA         in   N_REQ*DATA_W    operand A per slot (slot i at [i*DATA_W +: DATA_W])
//  rf_opB         in   N_REQ*DATA_W    operand B per slot
//  rs_tagDest     in   N_REQ*TAG_W     destination tag per slot
//  rs_control     in   N_REQ*CTRL_W    control bundle per slot
//  rs_bmask       in   N_REQ*BMASK_W   branch mask per slot
//  rs_bs_ptr      in   N_REQ*BSPTR_W   branch stack pointer per slot
//  br_mispredict  in   1               branch in br_mask mispredicted this cycle
//  br_correct     in   1               branch in br_mask resolved correct this cycle
//  br_mask        in   BMASK_W         one-hot resolving branch
//  fu_ready       in   1               FU consumes fus_* this cycle when fus_en=1
//  rs_grant       out  N_REQ           one-hot combinational grant; RS frees slot at edge
//  fus_en         out  1               output register valid
//  fus_opA/opB    out  DATA_W          registered operands
//  fus_tagDest    out  TAG_W           registered dest tag
//  fus_control    out  CTRL_W          registered control
//  fus_bmask      out  BMASK_W         registered branch mask (live-updated)
//  fus_bs_ptr     out  BSPTR_W         registered branch stack pointer
// BEHAVIOUR
//  - Reset: fus_en=0, all payload regs 0, tag reg ZERO_TAG, rr_ptr=0; rs_grant=0 during reset.
//  - kill = br_mispredict & (held_bmask & br_mask)!=0. slot_free = !fus_en | fu_ready | kill.
//  - Eligible slot i: rs_fu_en[i] & !(br_mispredict & (rs_bmask[i] & br_mask)!=0).
//  - Grant only if slot_free & any eligible; exactly one rs_grant bit set, else all 0.
//  - Latency 1: granted at edge t -> fus_en=1 with that payload from cycle t+1.
//  - No grant & slot_free: fus_en<=0. !slot_free: register holds all fields (stall).
//  - Stored bmask on capture: rs_bmask[w] & ~br_mask if br_correct, else rs_bmask[w].
//    Held entry under br_correct: held_bmask <= held_bmask & ~br_mask.
//  - fus_en=0 -> outputs forced: opA/opB/control/bmask/bs_ptr=0, tagDest=ZERO_TAG.
//  - Simultaneous consume+grant: back-to-back issue, no bubble. kill+grant: new entry loads.
//  - br_mispredict & br_correct same cycle: illegal, not handled.
//  - Reset mid-stall: entry dropped, no grant that cycle.
// CONFIGURATION
//  FUS_ROUND_ROBIN_EN defined: rotating priority; search starts at rr_ptr, on grant
//    rr_ptr <= (winner+1) mod N_REQ; rr_ptr holds when no grant.
//  Undefined: fixed priority, lowest eligible index wins; rr_ptr absent.
// TESTING
//  1 N_REQ=2, rs_fu_en=01, opA={10,20}, opB={30,40}, tags={5,10}, fu_ready=1 -> grant=01;
//    next cycle fus_en=1, opA=20, opB=40, tag=10.
//  2 rs_fu_en=10 -> grant=10; next cycle opA=10, opB=30, tag=5. rs_fu_en=00 -> fus_en=0,
//    opA=opB=control=0, tag=ZERO_TAG.
//  3 Hold entry, fu_ready=0 2 cycles, rs_fu_en=11 -> grant=00, outputs stable; fu_ready=1 ->
//    grant non-zero, new payload next cycle.
//  4 Held bmask=0010, br_mispredict, br_mask=0010, fu_ready=0 -> fus_en=0 next cycle;
//    slot0 bmask=0010 not granted, slot1 bmask=0001 granted. br_correct same mask on
//    held 0011 -> fus_bmask=0001.
//  5 FUS_ROUND_ROBIN_EN, rs_fu_en=11 held 4 cycles, fu_ready=1 -> grants 01,10,01,10;
//    without macro -> 01 every cycle.
//  6 reset=1 mid-stall with fus_en=1 -> next cycle fus_en=0, tag=ZERO_TAG, grant=00.

Source files
------------

// File: rtl/fu_issue_select.sv
// fu_issue_select: picks one ready RS slot per cycle and registers its payload into the FU input stage.
// Optional macro FUS_ROUND_ROBIN_EN: rotating-priority selection instead of fixed lowest-index priority.
module fu_issue_select #(
    parameter int unsigned      N_REQ    = 2,
    parameter int unsigned      DATA_W   = 64,
    parameter int unsigned      TAG_W    = 6,
    parameter int unsigned      CTRL_W   = 179,
    parameter int unsigned      BMASK_W  = 4,
    parameter int unsigned      BSPTR_W  = 2,
    parameter logic [TAG_W-1:0] ZERO_TAG = {TAG_W{1'b1}}
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           rs_fu_en,
    input  logic [N_REQ*DATA_W-1:0]    rf_opA,
    input  logic [N_REQ*DATA_W-1:0]    rf_opB,
    input  logic [N_REQ*TAG_W-1:0]     rs_tagDest,
    input  logic [N_REQ*CTRL_W-1:0]    rs_control,
    input  logic [N_REQ*BMASK_W-1:0]   rs_bmask,
    input  logic [N_REQ*BSPTR_W-1:0]   rs_bs_ptr,
    input  logic                       br_mispredict,
    input  logic                       br_correct,
    input  logic [BMASK_W-1:0]         br_mask,
    input  logic                       fu_ready,
    output logic [N_REQ-1:0]           rs_grant,
    output logic                       fus_en,
    output logic [DATA_W-1:0]          fus_opA,
    output logic [DATA_W-1:0]          fus_opB,
    output logic [TAG_W-1:0]           fus_tagDest,
    output logic [CTRL_W-1:0]          fus_control,
    output logic [BMASK_W-1:0]         fus_bmask,
    output logic [BSPTR_W-1:0]         fus_bs_ptr
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic               valid_q;
    logic [DATA_W-1:0]  opa_q;
    logic [DATA_W-1:0]  opb_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CTRL_W-1:0]  ctrl_q;
    logic [BMASK_W-1:0] bmask_q;
    logic [BSPTR_W-1:0] bsptr_q;

`ifdef FUS_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   rr_ptr;
`endif

    logic [N_REQ-1:0]   eligible;
    logic               found;
    logic [IDX_W-1:0]   win_idx;
    int unsigned        sel_idx;
    logic               kill;
    logic               slot_free;
    logic               do_grant;

    logic [DATA_W-1:0]  sel_opa;
    logic [DATA_W-1:0]  sel_opb;
    logic [TAG_W-1:0]   sel_tag;
    logic [CTRL_W-1:0]  sel_ctrl;
    logic [BMASK_W-1:0] sel_bmask;
    logic [BSPTR_W-1:0] sel_bsptr;

    // A held entry dependent on the mispredicted branch is squashed and frees the stage.
    assign kill      = valid_q & br_mispredict & (|(bmask_q & br_mask));
    assign slot_free = ~valid_q | fu_ready | kill;

    // Requests on the wrong path of a mispredict are not eligible this cycle.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = rs_fu_en[i]
                        & ~(br_mispredict & (|(rs_bmask[i*BMASK_W +: BMASK_W] & br_mask)));
        end
    end

    // Priority search: from rr_ptr when rotating, else from index 0.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sel_idx = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef FUS_ROUND_ROBIN_EN
            sel_idx = (32'(rr_ptr) + k) % N_REQ;
`else
            sel_idx = k;
`endif
            if (!found && eligible[sel_idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(sel_idx);
            end
        end
    end

    assign do_grant = found & slot_free & ~reset;

    always_comb begin
        rs_grant = '0;
        if (do_grant) begin
            rs_grant[win_idx] = 1'b1;
        end
    end

    assign sel_opa   = rf_opA[32'(win_idx)*DATA_W +: DATA_W];
    assign sel_opb   = rf_opB[32'(win_idx)*DATA_W +: DATA_W];
    assign sel_tag   = rs_tagDest[32'(win_idx)*TAG_W +: TAG_W];
    assign sel_ctrl  = rs_control[32'(win_idx)*CTRL_W +: CTRL_W];
    assign sel_bmask = rs_bmask[32'(win_idx)*BMASK_W +: BMASK_W];
    assign sel_bsptr = rs_bs_ptr[32'(win_idx)*BSPTR_W +: BSPTR_W];

    // FU input register: capture on grant, drain when free, otherwise hold (stall).
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            tag_q   <= ZERO_TAG;
            ctrl_q  <= '0;
            bmask_q <= '0;
            bsptr_q <= '0;
        end else if (slot_free) begin
            if (do_grant) begin
                valid_q <= 1'b1;
                opa_q   <= sel_opa;
                opb_q   <= sel_opb;
                tag_q   <= sel_tag;
                ctrl_q  <= sel_ctrl;
                bmask_q <= br_correct ? (sel_bmask & ~br_mask) : sel_bmask;
                bsptr_q <= sel_bsptr;
            end else begin
                valid_q <= 1'b0;
                opa_q   <= '0;
                opb_q   <= '0;
                tag_q   <= ZERO_TAG;
                ctrl_q  <= '0;
                bmask_q <= '0;
                bsptr_q <= '0;
            end
        end else if (br_correct) begin
            bmask_q <= bmask_q & ~br_mask;
        end
    end

`ifdef FUS_ROUND_ROBIN_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (do_grant) begin
            rr_ptr <= IDX_W'((32'(win_idx) + 1) % N_REQ);
        end
    end
`endif

    assign fus_en      = valid_q;
    assign fus_opA     = valid_q ? opa_q   : '0;
    assign fus_opB     = valid_q ? opb_q   : '0;
    assign fus_tagDest = valid_q ? tag_q   : ZERO_TAG;
    assign fus_control = valid_q ? ctrl_q  : '0;
    assign fus_bmask   = valid_q ? bmask_q : '0;
    assign fus_bs_ptr  = valid_q ? bsptr_q : '0;

endmodule

// File: tb/tb_fu_issue_select.sv
// Directed bench for fu_issue_select (N_REQ=2, default widths); expectations follow FUS_ROUND_ROBIN_EN.
module tb_fu_issue_select;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    rs_fu_en;
    logic [127:0]  rf_opA;
    logic [127:0]  rf_opB;
    logic [11:0]   rs_tagDest;
    logic [357:0]  rs_control;
    logic [7:0]    rs_bmask;
    logic [3:0]    rs_bs_ptr;
    logic          br_mispredict;
    logic          br_correct;
    logic [3:0]    br_mask;
    logic          fu_ready;
    logic [1:0]    rs_grant;
    logic          fus_en;
    logic [63:0]   fus_opA;
    logic [63:0]   fus_opB;
    logic [5:0]    fus_tagDest;
    logic [178:0]  fus_control;
    logic [3:0]    fus_bmask;
    logic [1:0]    fus_bs_ptr;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] ZT = 6'h3F;

`ifdef FUS_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    fu_issue_select dut (
        .clock(clock), .reset(reset), .rs_fu_en(rs_fu_en), .rf_opA(rf_opA), .rf_opB(rf_opB),
        .rs_tagDest(rs_tagDest), .rs_control(rs_control), .rs_bmask(rs_bmask),
        .rs_bs_ptr(rs_bs_ptr), .br_mispredict(br_mispredict), .br_correct(br_correct),
        .br_mask(br_mask), .fu_ready(fu_ready), .rs_grant(rs_grant), .fus_en(fus_en),
        .fus_opA(fus_opA), .fus_opB(fus_opB), .fus_tagDest(fus_tagDest),
        .fus_control(fus_control), .fus_bmask(fus_bmask), .fus_bs_ptr(fus_bs_ptr)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic [5:0] t, input logic [178:0] c,
                            input logic [3:0] bm, input logic [1:0] bs);
        rf_opA[i*64 +: 64]      = a;
        rf_opB[i*64 +: 64]      = b;
        rs_tagDest[i*6 +: 6]    = t;
        rs_control[i*179 +: 179] = c;
        rs_bmask[i*4 +: 4]      = bm;
        rs_bs_ptr[i*2 +: 2]     = bs;
    endtask

    task automatic test_reset();
        reset = 1'b1; rs_fu_en = 2'b11; fu_ready = 1'b1;
        step(); step();
        checks++; if (rs_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", rs_grant); end
        checks++; if (fus_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", fus_en); end
        checks++; if (fus_tagDest !== ZT) begin errors++; $display("FAIL reset_tag got=%0h exp=3f", fus_tagDest); end
        checks++; if (fus_opA !== 64'd0 || fus_control !== 179'd0 || fus_bmask !== 4'd0)
            begin errors++; $display("FAIL reset_payload opA=%0h ctrl=%0h bm=%0h exp=0", fus_opA, fus_control, fus_bmask); end
        reset = 1'b0; rs_fu_en = 2'b00;
        step();
    endtask

    task automatic test_basic();
        rs_fu_en = 2'b01; #1;
        checks++; if (rs_grant !== 2'b01) begin errors++; $display("FAIL basic_grant0 got=%b exp=01", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b1 || fus_opA !== 64'd20 || fus_opB !== 64'd40 || fus_tagDest !== 6'd10)
            begin errors++; $display("FAIL basic_slot0 en=%b opA=%0d opB=%0d tag=%0d exp 1/20/40/10", fus_en, fus_opA, fus_opB, fus_tagDest); end
        checks++; if (fus_control !== 179'h111 || fus_bs_ptr !== 2'd1)
            begin errors++; $display("FAIL basic_ctrl0 ctrl=%0h bs=%0d exp 111/1", fus_control, fus_bs_ptr); end
        rs_fu_en = 2'b10; #1;
        checks++; if (rs_grant !== 2'b10) begin errors++; $display("FAIL basic_grant1 got=%b exp=10", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b1 || fus_opA !== 64'd10 || fus_opB !== 64'd30 || fus_tagDest !== 6'd5)
            begin errors++; $display("FAIL basic_slot1 en=%b opA=%0d opB=%0d tag=%0d exp 1/10/30/5", fus_en, fus_opA, fus_opB, fus_tagDest); end
        rs_fu_en = 2'b00; #1;
        checks++; if (rs_grant !== 2'b00) begin errors++; $display("FAIL basic_nogrant got=%b exp=00", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b0 || fus_opA !== 64'd0 || fus_opB !== 64'd0 || fus_control !== 179'd0 || fus_tagDest !== ZT)
            begin errors++; $display("FAIL basic_idle en=%b opA=%0h opB=%0h ctrl=%0h tag=%0h exp 0/0/0/0/3f", fus_en, fus_opA, fus_opB, fus_control, fus_tagDest); end
    endtask

    task automatic test_stall();
        logic [1:0]  eg;
        logic [63:0] eo;
        rs_fu_en = 2'b01; step();
        fu_ready = 1'b0; rs_fu_en = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (rs_grant !== 2'b00) begin errors++; $display("FAIL stall_grant c=%0d got=%b exp=00", c, rs_grant); end
            step();
            checks++; if (fus_en !== 1'b1 || fus_opA !== 64'd20 || fus_tagDest !== 6'd10)
                begin errors++; $display("FAIL stall_hold c=%0d en=%b opA=%0d tag=%0d exp 1/20/10", c, fus_en, fus_opA, fus_tagDest); end
        end
        fu_ready = 1'b1; #1;
        eg = RR ? 2'b10 : 2'b01;
        eo = RR ? 64'd10 : 64'd20;
        checks++; if (rs_grant !== eg) begin errors++; $display("FAIL stall_release_grant got=%b exp=%b", rs_grant, eg); end
        step();
        checks++; if (fus_en !== 1'b1 || fus_opA !== eo) begin errors++; $display("FAIL stall_release_data en=%b opA=%0d exp 1/%0d", fus_en, fus_opA, eo); end
        rs_fu_en = 2'b00; step();
    endtask

    task automatic test_branch();
        set_slot(0, 64'd20, 64'd40, 6'd10, 179'h111, 4'b0010, 2'd1);
        set_slot(1, 64'd10, 64'd30, 6'd5,  179'h222, 4'b0001, 2'd2);
        rs_fu_en = 2'b01; step();
        checks++; if (fus_bmask !== 4'b0010) begin errors++; $display("FAIL br_capture got=%b exp=0010", fus_bmask); end
        fu_ready = 1'b0; rs_fu_en = 2'b11; br_mispredict = 1'b1; br_mask = 4'b0010; #1;
        checks++; if (rs_grant !== 2'b10) begin errors++; $display("FAIL br_kill_grant got=%b exp=10", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b1 || fus_opA !== 64'd10 || fus_bmask !== 4'b0001)
            begin errors++; $display("FAIL br_kill_reload en=%b opA=%0d bm=%b exp 1/10/0001", fus_en, fus_opA, fus_bmask); end
        rs_fu_en = 2'b00; br_mask = 4'b0001; #1;
        checks++; if (rs_grant !== 2'b00) begin errors++; $display("FAIL br_kill_nogrant got=%b exp=00", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b0 || fus_tagDest !== ZT) begin errors++; $display("FAIL br_kill_drop en=%b tag=%0h exp 0/3f", fus_en, fus_tagDest); end
        br_mispredict = 1'b0; br_mask = 4'b0000;
        set_slot(0, 64'd20, 64'd40, 6'd10, 179'h111, 4'b0011, 2'd1);
        fu_ready = 1'b1; rs_fu_en = 2'b01; step();
        checks++; if (fus_bmask !== 4'b0011) begin errors++; $display("FAIL br_load0011 got=%b exp=0011", fus_bmask); end
        fu_ready = 1'b0; rs_fu_en = 2'b00; br_correct = 1'b1; br_mask = 4'b0010; step();
        checks++; if (fus_en !== 1'b1 || fus_bmask !== 4'b0001) begin errors++; $display("FAIL br_correct_held en=%b bm=%b exp 1/0001", fus_en, fus_bmask); end
        set_slot(1, 64'd10, 64'd30, 6'd5, 179'h222, 4'b0110, 2'd2);
        fu_ready = 1'b1; rs_fu_en = 2'b10; br_mask = 4'b0100; step();
        checks++; if (fus_opA !== 64'd10 || fus_bmask !== 4'b0010) begin errors++; $display("FAIL br_correct_capture opA=%0d bm=%b exp 10/0010", fus_opA, fus_bmask); end
        br_correct = 1'b0; br_mask = 4'b0000; rs_fu_en = 2'b00;
        set_slot(0, 64'd20, 64'd40, 6'd10, 179'h111, 4'b0000, 2'd1);
        set_slot(1, 64'd10, 64'd30, 6'd5,  179'h222, 4'b0000, 2'd2);
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0]  eg;
        logic [63:0] eo;
        rs_fu_en = 2'b11; fu_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            eg = (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
            eo = (eg == 2'b10) ? 64'd10 : 64'd20;
            checks++; if (rs_grant !== eg) begin errors++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, rs_grant, eg); end
            step();
            checks++; if (fus_en !== 1'b1 || fus_opA !== eo) begin errors++; $display("FAIL b2b_data c=%0d en=%b opA=%0d exp 1/%0d", c, fus_en, fus_opA, eo); end
        end
    endtask

    task automatic test_reset_mid_stall();
        fu_ready = 1'b0; rs_fu_en = 2'b11; step();
        checks++; if (fus_en !== 1'b1) begin errors++; $display("FAIL rst_stall_pre en=%b exp=1", fus_en); end
        reset = 1'b1; #1;
        checks++; if (rs_grant !== 2'b00) begin errors++; $display("FAIL rst_stall_grant got=%b exp=00", rs_grant); end
        step();
        checks++; if (fus_en !== 1'b0 || fus_tagDest !== ZT || rs_grant !== 2'b00)
            begin errors++; $display("FAIL rst_stall_after en=%b tag=%0h grant=%b exp 0/3f/00", fus_en, fus_tagDest, rs_grant); end
        reset = 1'b0; rs_fu_en = 2'b00; step();
    endtask

    initial begin
        reset = 1'b1; rs_fu_en = '0; rf_opA = '0; rf_opB = '0; rs_tagDest = '0; rs_control = '0;
        rs_bmask = '0; rs_bs_ptr = '0; br_mispredict = 1'b0; br_correct = 1'b0; br_mask = '0; fu_ready = 1'b1;
        set_slot(0, 64'd20, 64'd40, 6'd10, 179'h111, 4'b0000, 2'd1);
        set_slot(1, 64'd10, 64'd30, 6'd5,  179'h222, 4'b0000, 2'd2);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
